// File: rtl/floating_point_adder.sv
// Single-precision adder, round toward zero, one registered stage.
// Optional FPADD_SATURATE_EN: finite overflow clamps to max-finite instead of infinity.
module floating_point_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  output logic [31:0] result
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic        signA, signB, zeroA, zeroB, infA, infB, nanA, nanB;
  logic        aGeB, signX, signY;
  logic [7:0]  expX, expY, shiftAmt;
  logic [22:0] fracX, fracY;
  logic [26:0] sigX, sigY, sigYShifted, lostMask;
  logic [27:0] sumWide;
  logic [26:0] diff, mantNorm;
  logic [4:0]  leadZeros;
  logic signed [9:0] expNorm;
  logic [31:0] overflowWord;
  logic [31:0] result_d, result_q;
  logic        valid_q;

  assign signA = A[31];
  assign signB = B[31];
  assign zeroA = (A[30:23] == 8'h00);
  assign zeroB = (B[30:23] == 8'h00);
  assign infA  = (A[30:23] == 8'hFF) && (A[22:0] == 23'h0);
  assign infB  = (B[30:23] == 8'hFF) && (B[22:0] == 23'h0);
  assign nanA  = (A[30:23] == 8'hFF) && (A[22:0] != 23'h0);
  assign nanB  = (B[30:23] == 8'hFF) && (B[22:0] != 23'h0);

  // Exponent-then-fraction magnitude order is just an unsigned compare of bits 30:0.
  assign aGeB  = (A[30:0] >= B[30:0]);
  assign signX = aGeB ? signA : signB;
  assign signY = aGeB ? signB : signA;
  assign expX  = aGeB ? A[30:23] : B[30:23];
  assign expY  = aGeB ? B[30:23] : A[30:23];
  assign fracX = aGeB ? A[22:0] : B[22:0];
  assign fracY = aGeB ? B[22:0] : A[22:0];
  assign sigX  = {1'b1, fracX, 3'b000};
  assign sigY  = {1'b1, fracY, 3'b000};
  assign shiftAmt = expX - expY;

`ifdef FPADD_SATURATE_EN
  assign overflowWord = {signX, 8'hFE, 23'h7FFFFF};
`else
  assign overflowWord = {signX, 8'hFF, 23'h0};
`endif

  // Alignment: bits shifted out of Y collapse into the sticky position.
  always_comb begin
    lostMask    = '0;
    sigYShifted = 27'd1;
    if (shiftAmt < 8'd27) begin
      lostMask    = (27'd1 << shiftAmt) - 27'd1;
      sigYShifted = (sigY >> shiftAmt) | {26'd0, |(sigY & lostMask)};
    end
  end

  always_comb begin
    sumWide   = '0;
    diff      = '0;
    leadZeros = '0;
    mantNorm  = '0;
    expNorm   = '0;
    if (signX == signY) begin
      sumWide = {1'b0, sigX} + {1'b0, sigYShifted};
      if (sumWide[27]) begin
        mantNorm = sumWide[27:1];
        expNorm  = {2'b00, expX} + 10'd1;
      end else begin
        mantNorm = sumWide[26:0];
        expNorm  = {2'b00, expX};
      end
    end else begin
      diff = sigX - sigYShifted;
      for (int i = 0; i < 27; i++) begin
        if (diff[i]) leadZeros = 5'(26 - i);
      end
      mantNorm = diff << leadZeros;
      expNorm  = {2'b00, expX} - {5'b00000, leadZeros};
    end
  end

  // A clear hidden bit after normalization only happens for an exact cancellation.
  always_comb begin
    result_d = {signX, expNorm[7:0], 23'(mantNorm >> 3)};
    if (!mantNorm[26])              result_d = 32'h0;
    else if (expNorm >= 10'sd255)   result_d = overflowWord;
    else if (expNorm <= 10'sd0)     result_d = {signX, 31'h0};

    if (nanA || nanB)                         result_d = QNAN;
    else if (infA && infB && (signA != signB)) result_d = QNAN;
    else if (infA)                            result_d = A;
    else if (infB)                            result_d = B;
    else if (zeroA && zeroB)                  result_d = {signA & signB, 31'h0};
    else if (zeroA)                           result_d = B;
    else if (zeroB)                           result_d = A;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_floating_point_adder.sv
// Scoreboard bench for floating_point_adder: expected words are queued at drive
// time and popped when the one-cycle-later result is sampled on the falling edge.
module tb_floating_point_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] A, B;
  logic        out_valid;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastExp;

`ifdef FPADD_SATURATE_EN
  localparam logic [31:0] POS_OVF = 32'h7F7FFFFF;
  localparam logic [31:0] NEG_OVF = 32'hFF7FFFFF;
`else
  localparam logic [31:0] POS_OVF = 32'h7F800000;
  localparam logic [31:0] NEG_OVF = 32'hFF800000;
`endif

  floating_point_adder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    in_valid = 1'b1;
    A = a;
    B = b;
    expQ.push_back(e);
    lastExp = e;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0)
      $display("[TB] FAIL reset_state: got valid=%b result=%h, expected valid=0 result=00000000", out_valid, result);
    else passes++;
    rst = 1'b0;
  endtask

  // Runs a table of operations back-to-back and checks each one a cycle later.
  task automatic test_vectors(input string name, input logic [31:0] va[$], input logic [31:0] vb[$],
                              input logic [31:0] ve[$]);
    logic [31:0] expWord;
    int n = va.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (expQ.size() == 0)
          $display("[TB] FAIL %s[%0d]: scoreboard empty, got valid=%b result=%h", name, i - 1, out_valid, result);
        else begin
          expWord = expQ.pop_front();
          if (out_valid !== 1'b1 || result !== expWord)
            $display("[TB] FAIL %s[%0d]: %h+%h got valid=%b result=%h, expected valid=1 result=%h",
                     name, i - 1, va[i-1], vb[i-1], out_valid, result, expWord);
          else passes++;
        end
      end
      if (i < n) applyStimulus(va[i], vb[i], ve[i]);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== lastExp)
      $display("[TB] FAIL %s_idle_hold: got valid=%b result=%h, expected valid=0 result=%h",
               name, out_valid, result, lastExp);
    else passes++;
  endtask

  task automatic test_basic();
    test_vectors("basic",
      '{32'h41200000, 32'hC2108000, 32'h3F800000, 32'h3F800000, 32'h3F000000},
      '{32'h40A00000, 32'hC1890000, 32'h3F800000, 32'hBF000000, 32'hBF800000},
      '{32'h41700000, 32'hC2550000, 32'h40000000, 32'h3F000000, 32'hBF000000});
  endtask

  task automatic test_back_to_back();
    test_vectors("b2b",
      '{32'hC1200000, 32'h42100000, 32'h41200000},
      '{32'hC0A00000, 32'hC2100000, 32'h40A00000},
      '{32'hC1700000, 32'h00000000, 32'h41700000});
  endtask

  task automatic test_specials();
    test_vectors("special",
      '{32'h7F800000, 32'h7F800000, 32'h7FFFFFFF, 32'h3F800000, 32'hFF800000, 32'h3F800000,
        32'h00000000, 32'hC0400000, 32'h3F800000, 32'h00000001, 32'h80000000, 32'h80000001},
      '{32'h7F800000, 32'hFF800000, 32'h3F800000, 32'hFFC00001, 32'h3F800000, 32'hFF800000,
        32'h40400000, 32'h80000000, 32'h00400000, 32'h80000000, 32'h80000000, 32'h80000000},
      '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'hFF800000,
        32'h40400000, 32'hC0400000, 32'h3F800000, 32'h00000000, 32'h80000000, 32'h80000000});
  endtask

  task automatic test_boundaries();
    test_vectors("boundary",
      '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7E800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
        32'h00800000},
      '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7E800000, 32'h33800000, 32'h0D800000, 32'hB0800000,
        32'h80C00000},
      '{POS_OVF, NEG_OVF, 32'h7F000000, 32'h3F800000, 32'h3F800000, 32'h3F7FFFFF,
        32'h80000000});
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    A = 32'h41200000;
    B = 32'h40A00000;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0)
      $display("[TB] FAIL reset_inflight: got valid=%b result=%h, expected valid=0 result=00000000", out_valid, result);
    else passes++;
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0)
      $display("[TB] FAIL reset_idle: got valid=%b result=%h, expected valid=0 result=00000000", out_valid, result);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_specials();
    test_boundaries();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
